// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Holds the FSM state encoding, the slice width and the default slice count.
package nibble_serial_subtractor_pkg;

  localparam int unsigned NIBBLE_W        = 4;
  localparam int unsigned NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/cla_sub_4bit.sv
// Combinational 4-bit subtract slice: d = x + ~y + ~bi, built from lookahead carries.
// The borrow-out is the inverted carry-out of that sum.
module cla_sub_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x & ~y;
  assign p = x ^ ~y;

  // A borrow-in of 0 is a carry-in of 1 into x + ~y.
  assign c[0] = ~bi;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d  = p ^ c[3:0];
  assign bo = ~c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: computes a - b - bin one nibble per cycle with a single shared slice.
// Valid/ready on both sides; result held in DONE until the consumer accepts it.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      bin,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] diff,
  output logic                      bout,
  output logic                      ovf,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e state_q, state_d;

  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        diff_q, diff_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                borrow_q, borrow_d;
  logic                bout_q, bout_d;
  logic                ovf_q, ovf_d;

  logic [31:0]         nib_lsb;
  logic [NIBBLE_W-1:0] nib_x;
  logic [NIBBLE_W-1:0] nib_y;
  logic [NIBBLE_W-1:0] nib_d;
  logic                nib_bo;
  logic                last_nibble;

  assign last_nibble = (cnt_q == LastCnt);
  assign nib_lsb     = 32'(cnt_q) * NIBBLE_W;
  assign nib_x       = a_q[nib_lsb +: NIBBLE_W];
  assign nib_y       = b_q[nib_lsb +: NIBBLE_W];

  cla_sub_4bit u_slice (
    .x  (nib_x),
    .y  (nib_y),
    .bi (borrow_q),
    .d  (nib_d),
    .bo (nib_bo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)    state_d = StCalc;
      StCalc:  if (last_nibble) state_d = StDone;
      StDone:  if (out_ready)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    diff      = diff_q;
    bout      = bout_q;
    ovf       = ovf_q;
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
        end
      end
      StCalc: begin
        diff_d[nib_lsb +: NIBBLE_W] = nib_d;
        borrow_d = nib_bo;
        cnt_d    = cnt_q + 1'b1;
        if (last_nibble) begin
          // The top nibble is being written this cycle, so take its sign from the slice.
          bout_d = nib_bo;
          ovf_d  = (a_q[W-1] != b_q[W-1]) & (nib_d[NIBBLE_W-1] != a_q[W-1]);
        end
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES (16 by default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  W  minuend.
REQ-005 b  input  W  subtrahend.
REQ-006 bin  input  1  borrow-in.
REQ-007 in_valid  input  1  operands and bin are valid.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 diff  output  W  a - b - bin, modulo 2^W.
REQ-010 bout  output  1  unsigned borrow-out.
REQ-011 ovf  output  1  two's-complement overflow.
REQ-012 out_valid  output  1  diff, bout and ovf are valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 FSM states: IDLE, CALC, DONE; no other states are reachable.
REQ-015 IDLE: in_ready=1 and out_valid=0; when in_valid=1, the block latches a, b and bin, clears nibble counter cnt to 0, and moves to CALC.
REQ-016 in_ready is 1 only in IDLE, so a new operand is never accepted in the same cycle as a result handshake.
REQ-017 CALC: each cycle processes nibble cnt (bits 4*cnt+3:4*cnt) and writes that nibble of diff.
REQ-018 Borrow register: loaded with bin on accept; each CALC cycle it takes the borrow-out of the nibble just processed.
REQ-019 CALC: cnt increments each cycle; when cnt = NIBBLES-1 the FSM moves to DONE.
REQ-020 On entry to DONE, bout = final borrow register value and ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]), both from the latched operands.
REQ-021 Latency: accept at edge E0; out_valid rises after edge E(NIBBLES), which is E4 by default.
REQ-022 DONE: out_valid=1; diff, bout and ovf stay stable until out_ready=1; on that cycle the FSM returns to IDLE.
REQ-023 Changes on a, b, bin or in_valid during CALC or DONE have no effect.
REQ-024 out_ready is ignored outside DONE.
REQ-025 diff is not guaranteed meaningful while out_valid=0; the bench checks it only when out_valid=1.
REQ-026 Back-to-back throughput: one result per NIBBLES+2 cycles.

Reset
REQ-027 When rst=1 at an edge, in every state including mid-CALC: FSM goes to IDLE, cnt=0, borrow register=0, diff=0, bout=0, ovf=0, out_valid=0.
REQ-028 in_ready=1 in the first cycle after rst is released.
REQ-029 rst has priority over every handshake in the same cycle.

Structure
REQ-030 Shared package holds the FSM state enum, NIBBLE_W=4 and the default NIBBLES.
REQ-031 One sub-module, cla_sub_4bit: combinational 4-bit slice computing x + ~y + ~bi.
REQ-032 cla_sub_4bit uses lookahead carries (G = x & ~y, P = x ^ ~y) and outputs borrow = ~carry_out; one instance is time-shared across nibbles.

Verification
REQ-033 a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-034 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
REQ-035 a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-036 a=0x1000, b=0x0001, bin=1 -> diff=0x0FFE, bout=0, borrow ripples through nibbles 0-2.
REQ-037 out_ready held 0 for 3 cycles in DONE -> outputs stable and in_ready=0 throughout; after the handshake, the next operand is accepted one cycle later.
REQ-038 rst pulsed at cnt=2 -> next cycle IDLE, out_valid=0, diff=0, in_ready=1; a following 0x0005-0x0003 yields 0x0002, bout=0.
